// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: PC generator, in-order imem request port and a DEPTH-entry {pc, instr} prefetch FIFO.
// A response captured at edge N is visible on id_* after edge N; requests are credit-limited so a push never overflows.
module if_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              CNT_W    = $clog2(DEPTH+1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [XLEN-1:0]  imem_rdata,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [XLEN-1:0]  id_pc,
    output logic [XLEN-1:0]  id_instr,
    output logic [CNT_W-1:0] q_count
);
    localparam int               PTR_W   = $clog2(DEPTH);
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W+1)'(DEPTH);

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0]  pc_mem_q    [DEPTH];
    logic [XLEN-1:0]  instr_mem_q [DEPTH];

    logic [CNT_W:0]   credit_used;
    logic [XLEN-1:0]  redirect_aligned;
    logic             accept, rsp_ok, push, pop;
    logic             unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign redirect_aligned     = {redirect_pc[XLEN-1:2], 2'b00};

    // Entries already queued plus responses still owed must never exceed FIFO capacity.
    assign credit_used = {1'b0, count_q} + {1'b0, outst_q};
    assign imem_req    = !reset && !redirect_valid && (credit_used < DEPTH_C);
    assign imem_addr   = fetch_pc_q;
    assign accept      = imem_req && imem_gnt;

    // A response with nothing outstanding is a protocol violation and is ignored.
    assign rsp_ok = imem_rvalid && (outst_q != '0);
    assign push   = !redirect_valid && rsp_ok && (drop_q == '0);
    assign pop    = !redirect_valid && id_valid && id_ready;

    assign id_valid = (count_q != '0);
    assign id_pc    = id_valid ? pc_mem_q[rd_q]    : '0;
    assign id_instr = id_valid ? instr_mem_q[rd_q] : '0;
    assign q_count  = count_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        count_d    = count_q;
        drop_d     = drop_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        outst_d    = outst_q + CNT_W'(accept) - CNT_W'(rsp_ok);
        if (accept) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
        if (redirect_valid) begin
            // Everything still in flight after this cycle belongs to the old path.
            fetch_pc_d = redirect_aligned;
            resp_pc_d  = redirect_aligned;
            count_d    = '0;
            wr_d       = '0;
            rd_d       = '0;
            drop_d     = outst_q - CNT_W'(rsp_ok);
        end else begin
            if (rsp_ok && (drop_q != '0)) begin
                drop_d = drop_q - CNT_W'(1);
            end
            if (push) begin
                wr_d      = wr_q + PTR_W'(1);
                resp_pc_d = resp_pc_q + XLEN'(4);
            end
            if (pop) begin
                rd_d = rd_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            pc_mem_q[wr_q]    <= resp_pc_q;
            instr_mem_q[wr_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized bench for if_fetch_queue against a queue-based model of fetch, in-flight requests and the prefetch FIFO.
module tb_if_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [2:0]  q_count;

    if_fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr),
        .q_count(q_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          due;
        bit          stale;
    } req_t;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    req_t        inflight[$];
    ent_t        fifo[$];
    logic [31:0] m_fetch_pc = RESET_PC;
    int          cyc = 0;
    int          last_due = -1;
    bit          prev_rst = 1'b0;
    int          errors = 0;
    int          checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then advance the model.
    task automatic step(input bit rst, input bit redir, input logic [31:0] rpc,
                        input bit gnt, input bit rdy, input int lat, input bit spurious);
        bit   rsp, spur, exp_req, acc, do_pop;
        req_t r;
        ent_t e;
        @(negedge clk);
        rsp  = !rst && inflight.size() > 0 && inflight[0].due == cyc;
        spur = !rst && inflight.size() == 0 && spurious;
        reset          = rst;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_gnt       = gnt;
        id_ready       = rdy;
        imem_rvalid    = rsp || spur;
        imem_rdata     = rsp ? inflight[0].data : $urandom;
        #1;
        exp_req = !rst && !redir && (fifo.size() + inflight.size() < DEPTH);
        check_eq("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) check_eq("imem_addr", imem_addr, m_fetch_pc);
        check_eq("id_valid", 32'(id_valid), 32'(fifo.size() != 0));
        check_eq("q_count", 32'(q_count), 32'(fifo.size()));
        if (fifo.size() > 0) begin
            check_eq("id_pc", id_pc, fifo[0].pc);
            check_eq("id_instr", id_instr, fifo[0].instr);
        end else if (prev_rst) begin
            check_eq("id_pc_rst", id_pc, 32'h0);
            check_eq("id_instr_rst", id_instr, 32'h0);
        end
        prev_rst = rst;

        if (rst) begin
            fifo.delete();
            inflight.delete();
            m_fetch_pc = RESET_PC;
            last_due   = cyc;
        end else begin
            acc    = exp_req && gnt;
            do_pop = !redir && fifo.size() > 0 && rdy;
            if (do_pop) void'(fifo.pop_front());
            if (rsp) begin
                r = inflight.pop_front();
                if (!redir && !r.stale) begin
                    e.pc    = r.addr;
                    e.instr = r.data;
                    fifo.push_back(e);
                end
            end
            if (redir) begin
                fifo.delete();
                foreach (inflight[i]) inflight[i].stale = 1'b1;
                m_fetch_pc = rpc & 32'hFFFF_FFFC;
            end
            if (acc) begin
                r.addr  = m_fetch_pc;
                r.data  = $urandom;
                r.due   = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                r.stale = 1'b0;
                last_due = r.due;
                inflight.push_back(r);
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end
        cyc++;
    endtask

    initial begin
        bit found;
        bit rd;
        logic [31:0] rpc;
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b0;

        repeat (3) step(1, 0, 0, 1, 1, 1, 0);
        // Streaming with 1-cycle memory.
        repeat (20) step(0, 0, 0, 1, 1, 1, 0);
        // Decode stall fills the queue, then drains in order.
        repeat (12) step(0, 0, 0, 1, 0, 1, 0);
        repeat (10) step(0, 0, 0, 1, 1, 1, 0);
        // 3-cycle memory with requests in flight, then redirects.
        repeat (6) step(0, 0, 0, 1, 1, 3, 0);
        step(0, 1, 32'h0000_0100, 1, 1, 3, 0);
        repeat (15) step(0, 0, 0, 1, 1, 3, 0);
        step(0, 1, 32'h0000_0102, 1, 1, 1, 0);
        repeat (10) step(0, 0, 0, 1, 1, 1, 0);
        // Redirect while popping with a response arriving.
        step(0, 1, 32'hFFFF_FFF8, 1, 1, 1, 0);
        repeat (8) step(0, 0, 0, 1, 1, 1, 0);
        // Reset mid-operation with a partly full queue and a request outstanding.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (fifo.size() == 3 && inflight.size() == 1) found = 1'b1;
            else step(0, 0, 0, 1, 0, 1, 0);
        end
        check_eq("reach_q3_o1", 32'(found), 32'd1);
        step(1, 0, 0, 1, 1, 1, 0);
        repeat (10) step(0, 0, 0, 1, 1, 1, 0);

        for (int i = 0; i < 3000; i++) begin
            rpc = $urandom;
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFE0 | (rpc & 32'h1F);
            rd = ($urandom_range(0, 2) != 0);
            step($urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0, rpc,
                 $urandom_range(0, 3) != 0, rd, $urandom_range(1, 4),
                 $urandom_range(0, 7) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
Parametrised instruction-fetch front end. It replaces the single-register PC/IF_ID path with a PC generator, an instruction-memory request port that tracks outstanding requests, and a DEPTH-entry prefetch FIFO of {pc, instr} pairs. Decode consumes entries through a valid/ready handshake. A branch redirect flushes the queue and discards any responses still in flight from the old path.

Parameters:
XLEN, 32, width of PC and instruction words
DEPTH, 4, prefetch FIFO entries; power of two, at least 2
RESET_PC, 32'h0000_0000, fetch PC loaded at reset
CNT_W, $clog2(DEPTH+1), width of the occupancy and outstanding counters

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
redirect_valid  in  1  branch/jump taken; flush and restart fetch
redirect_pc  in  XLEN  new fetch address; bits [1:0] ignored and forced to 0
imem_req  out  1  fetch request valid
imem_addr  out  XLEN  fetch address, word aligned
imem_gnt  in  1  memory accepts the request this cycle (imem_req && imem_gnt)
imem_rvalid  in  1  response valid; responses return in order, latency of 1 or more cycles
imem_rdata  in  XLEN  instruction word
id_valid  out  1  FIFO head is valid
id_ready  in  1  decode accepts the head (low = stall)
id_pc  out  XLEN  PC of the head entry
id_instr  out  XLEN  instruction of the head entry
q_count  out  CNT_W  current FIFO occupancy

Behaviour:
- Reset values: fetch_pc = resp_pc = RESET_PC; FIFO empty; outstanding = 0; drop_cnt = 0.
- Reset output values: imem_req = 0, id_valid = 0, id_pc = 0, id_instr = 0, q_count = 0.
- Reset overrides every other input in the same cycle, including a redirect.
- Issue:
  - imem_req = !reset && !redirect_valid && (q_count + outstanding) < DEPTH.
  - imem_addr = fetch_pc.
  - On accept (imem_req && imem_gnt): fetch_pc += 4 and outstanding += 1.
  - The credit rule guarantees a push never overflows the FIFO.
- Response handling, when imem_rvalid is asserted:
  - outstanding -= 1.
  - If drop_cnt != 0: discard the response and decrement drop_cnt.
  - Otherwise push {resp_pc, imem_rdata} and advance resp_pc by 4.
  - Accept and response in the same cycle: outstanding is unchanged.
  - imem_rvalid while outstanding == 0 is a protocol violation; it is ignored and no state changes.
- Dequeue:
  - id_valid = (q_count != 0); id_pc and id_instr are driven from the head entry.
  - Pop when id_valid && id_ready.
  - Push and pop in the same cycle leave q_count unchanged; this is legal even when the FIFO is full.
- Latency:
  - No bypass: a response captured at edge N is visible on id_* after edge N.
  - With 1-cycle memory, the first request issues in the first cycle after reset deasserts and id_valid rises 2 cycles later.
  - Sustained throughput is 1 instruction per cycle when imem_gnt = 1 and id_ready = 1.
- Redirect (redirect_valid = 1, with priority over push and pop):
  - FIFO is cleared; q_count = 0 next cycle; no pop occurs that cycle.
  - fetch_pc and resp_pc are loaded with {redirect_pc[XLEN-1:2], 2'b00}.
  - No request is issued in the redirect cycle.
  - Any response arriving in the redirect cycle is discarded.
  - drop_cnt = outstanding - imem_rvalid, i.e. every remaining in-flight response is dropped.
  - outstanding is updated normally, so drop_cnt <= outstanding always holds.
  - A new redirect while drop_cnt != 0 recomputes drop_cnt by the same rule.
- Wrap-around:
  - FIFO read/write pointers are log2(DEPTH) bits and wrap naturally.
  - fetch_pc and resp_pc wrap modulo 2^XLEN.
- Reset mid-operation (FIFO non-empty, requests outstanding): all state returns to reset values. Responses arriving afterwards are ignored under the outstanding == 0 rule; the environment must not return them.

Test Plan:
- Reset, 1-cycle memory, gnt = 1, id_ready = 1 -> imem_addr sequence 0, 4, 8, …; id_pc 0, 4, 8 on consecutive cycles, with the first id_valid 2 cycles after the first request.
- id_ready = 0 with DEPTH = 4 -> q_count reaches 4 and imem_req drops once (q_count + outstanding) = 4; raising id_ready drains entries in order and fetch resumes.
- 3-cycle memory latency, 2 requests outstanding, redirect_pc = 0x100 -> both old responses dropped; first id_valid shows id_pc = 0x100 with the new instruction; q_count never includes stale entries.
- redirect_pc = 0x102 -> first fetch address 0x100.
- redirect_valid and id_valid && id_ready in the same cycle, with a response arriving that same cycle -> no pop observed; the response is dropped; q_count = 0 next cycle.
- Reset asserted while q_count = 3 and outstanding = 1 -> next cycle id_valid = 0, q_count = 0, imem_req = 0; after release, fetch restarts at RESET_PC.
